// File: rtl/pipelined_carry_skip_adder.sv
// Purpose: pipelined carry-skip adder, one BLOCK-bit carry-skip block per stage, with signed overflow and per-block skip flags.
// Latency: WIDTH/BLOCK cycles from input accept to out_valid; one result per cycle when not stalled.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready depends only on out_valid/out_ready.
module pipelined_carry_skip_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum,
    output logic                   cout,
    output logic                   ovf,
    output logic [WIDTH/BLOCK-1:0] skip
);
    localparam int NBLK = WIDTH / BLOCK;

    // A partial final block would silently drop operand bits, so refuse to elaborate.
    if ((BLOCK < 1) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
        $fatal(1, "pipelined_carry_skip_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Stage registers. Stage k holds the transaction after block k has been added:
    // sum bits below (k+1)*BLOCK, the block carry-out, skip flags so far, and the
    // full operands (the next stage only consumes the bits above its own block).
    logic [NBLK-1:0]  r_vld;
    logic [NBLK-1:0]  r_carry;
    logic [WIDTH-1:0] r_a    [NBLK];
    logic [WIDTH-1:0] r_b    [NBLK];
    logic [WIDTH-1:0] r_sum  [NBLK];
    logic [NBLK-1:0]  r_skip [NBLK];
    logic             r_ovf;

    // Per-stage inputs (from the previous stage or the ports) and next-state values.
    logic             w_adv;
    logic [NBLK-1:0]  w_vld_in;
    logic [NBLK-1:0]  w_c_in;
    logic [NBLK-1:0]  w_c_nxt;
    logic [WIDTH-1:0] w_a_in     [NBLK];
    logic [WIDTH-1:0] w_b_in     [NBLK];
    logic [WIDTH-1:0] w_sum_in   [NBLK];
    logic [WIDTH-1:0] w_sum_nxt  [NBLK];
    logic [NBLK-1:0]  w_skip_in  [NBLK];
    logic [NBLK-1:0]  w_skip_nxt [NBLK];
    logic             w_ovf_nxt;

    // The pipeline moves as a unit: it advances unless a finished result is blocked.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLOCK-1:0] w_blk_a;
        logic [BLOCK-1:0] w_blk_b;
        logic [BLOCK-1:0] w_blk_sum;
        logic             w_blk_rco;
        logic             w_blk_p;

        if (k == 0) begin : g_first
            assign w_vld_in[0]  = in_valid;
            assign w_c_in[0]    = cin;
            assign w_a_in[0]    = a;
            assign w_b_in[0]    = b;
            assign w_sum_in[0]  = '0;
            assign w_skip_in[0] = '0;
        end else begin : g_next
            assign w_vld_in[k]  = r_vld[k-1];
            assign w_c_in[k]    = r_carry[k-1];
            assign w_a_in[k]    = r_a[k-1];
            assign w_b_in[k]    = r_b[k-1];
            assign w_sum_in[k]  = r_sum[k-1];
            assign w_skip_in[k] = r_skip[k-1];
        end

        assign w_blk_a = w_a_in[k][k*BLOCK +: BLOCK];
        assign w_blk_b = w_b_in[k][k*BLOCK +: BLOCK];

        // Ripple sum of the block; the skip mux below only replaces its carry-out.
        assign {w_blk_rco, w_blk_sum} = {1'b0, w_blk_a} + {1'b0, w_blk_b}
                                      + {{BLOCK{1'b0}}, w_c_in[k]};

        // All bits propagate: carry-in passes straight through on the skip path.
        assign w_blk_p    = &(w_blk_a ^ w_blk_b);
        assign w_c_nxt[k] = w_blk_p ? w_c_in[k] : w_blk_rco;

        // Bits above the finished blocks are always zero, so OR-ing in the new block is exact.
        assign w_sum_nxt[k]  = w_sum_in[k]  | (WIDTH'(w_blk_sum) << (k*BLOCK));
        assign w_skip_nxt[k] = w_skip_in[k] | (NBLK'(w_blk_p) << k);
    end

    // Overflow is resolved in the last stage so it is registered alongside sum and cout.
    assign w_ovf_nxt = (w_a_in[NBLK-1][WIDTH-1] == w_b_in[NBLK-1][WIDTH-1])
                    && (w_sum_nxt[NBLK-1][WIDTH-1] != w_a_in[NBLK-1][WIDTH-1]);

    // Shift every stage forward on advance, hold everything on stall, flush on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_carry <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                r_a[k]    <= '0;
                r_b[k]    <= '0;
                r_sum[k]  <= '0;
                r_skip[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld   <= w_vld_in;
            r_carry <= w_c_nxt;
            r_ovf   <= w_ovf_nxt;
            for (int k = 0; k < NBLK; k++) begin
                r_a[k]    <= w_a_in[k];
                r_b[k]    <= w_b_in[k];
                r_sum[k]  <= w_sum_nxt[k];
                r_skip[k] <= w_skip_nxt[k];
            end
        end
    end

    assign out_valid = r_vld[NBLK-1];
    assign sum       = r_sum[NBLK-1];
    assign cout      = r_carry[NBLK-1];
    assign ovf       = r_ovf;
    assign skip      = r_skip[NBLK-1];

endmodule
